// File: rtl/virtio_available_ring_scheduler.sv
// Round-robin scheduler sharing one available-ring read port between QUEUES handlers,
// with per-queue in-flight credit limits and tag-based response routing.
module virtio_available_ring_scheduler #(
  parameter  int QUEUES          = 4,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int QW              = $clog2(QUEUES)
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [QUEUES-1:0]    enable,
  input  logic [QUEUES-1:0]    req_tvalid,
  output logic [QUEUES-1:0]    req_tready,
  input  logic [QUEUES*2-1:0]  req_tid,
  input  logic [QUEUES*32-1:0] req_tdata,
  output logic                 tx_tvalid,
  input  logic                 tx_tready,
  output logic [1:0]           tx_tid,
  output logic [QW-1:0]        tx_tdest,
  output logic [31:0]          tx_tdata,
  input  logic                 rx_tvalid,
  output logic                 rx_tready,
  input  logic [QW-1:0]        rx_tdest,
  input  logic                 rx_tlast,
  input  logic [31:0]          rx_tdata,
  output logic [QUEUES-1:0]    rsp_tvalid,
  input  logic [QUEUES-1:0]    rsp_tready,
  output logic                 rsp_tlast,
  output logic [31:0]          rsp_tdata,
  output logic                 error
);

  logic              tx_tvalid_q, tx_tvalid_d;
  logic [1:0]        tx_tid_q, tx_tid_d;
  logic [QW-1:0]     tx_tdest_q, tx_tdest_d;
  logic [31:0]       tx_tdata_q, tx_tdata_d;
  logic [QW-1:0]     last_q, last_d;
  logic              error_q, error_d;
  logic [7:0]        credit_q [QUEUES];
  logic [7:0]        credit_d [QUEUES];

  logic [QUEUES-1:0] eligible;
  logic [QUEUES-1:0] completion;
  logic              loadable;
  logic              grant_valid;
  logic              grant_fire;
  logic [QW-1:0]     grant_idx;
  logic [QW-1:0]     search_idx;
  logic              rx_dest_ok;

  // Round-robin search starts one past the last granted queue.
  always_comb begin
    loadable    = !tx_tvalid_q || tx_tready;
    eligible    = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    search_idx  = '0;
    req_tready  = '0;
    for (int i = 0; i < QUEUES; i++) begin
      eligible[i] = enable[i] && req_tvalid[i] && (credit_q[i] < 8'(MAX_OUTSTANDING));
    end
    for (int k = 1; k <= QUEUES; k++) begin
      search_idx = QW'((int'(last_q) + k) % QUEUES);
      if (!grant_valid && eligible[search_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = search_idx;
      end
    end
    grant_fire = grant_valid && loadable && !areset;
    for (int i = 0; i < QUEUES; i++) begin
      req_tready[i] = grant_fire && (grant_idx == QW'(i));
    end
  end

  always_comb begin
    tx_tvalid_d = tx_tvalid_q;
    tx_tid_d    = tx_tid_q;
    tx_tdest_d  = tx_tdest_q;
    tx_tdata_d  = tx_tdata_q;
    last_d      = last_q;
    if (loadable) begin
      tx_tvalid_d = grant_fire;
      if (grant_fire) begin
        tx_tdest_d = grant_idx;
        last_d     = grant_idx;
        for (int i = 0; i < QUEUES; i++) begin
          if (grant_idx == QW'(i)) begin
            tx_tid_d   = req_tid[2*i +: 2];
            tx_tdata_d = req_tdata[32*i +: 32];
          end
        end
      end
    end
  end

  // Out-of-range tags are swallowed (ready high, no valid) and flagged.
  always_comb begin
    rx_dest_ok = (int'(rx_tdest) < QUEUES);
    rx_tready  = 1'b1;
    rsp_tvalid = '0;
    for (int i = 0; i < QUEUES; i++) begin
      if (rx_tdest == QW'(i)) begin
        rx_tready     = rsp_tready[i];
        rsp_tvalid[i] = rx_tvalid;
      end
    end
    completion = rsp_tvalid & {QUEUES{rx_tready && rx_tlast}};
  end

  // A completion against an empty counter is a protocol error and must not wrap.
  always_comb begin
    error_d = error_q || (rx_tvalid && !rx_dest_ok);
    for (int i = 0; i < QUEUES; i++) begin
      credit_d[i] = credit_q[i];
      if (completion[i] && (credit_q[i] == 8'd0)) begin
        error_d = 1'b1;
      end
      if (req_tready[i] && !(completion[i] && (credit_q[i] != 8'd0))) begin
        credit_d[i] = credit_q[i] + 8'd1;
      end else if (!req_tready[i] && completion[i] && (credit_q[i] != 8'd0)) begin
        credit_d[i] = credit_q[i] - 8'd1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      tx_tvalid_q <= 1'b0;
      tx_tid_q    <= '0;
      tx_tdest_q  <= '0;
      tx_tdata_q  <= '0;
      last_q      <= QW'(QUEUES - 1);
      error_q     <= 1'b0;
      for (int i = 0; i < QUEUES; i++) begin
        credit_q[i] <= '0;
      end
    end else begin
      tx_tvalid_q <= tx_tvalid_d;
      tx_tid_q    <= tx_tid_d;
      tx_tdest_q  <= tx_tdest_d;
      tx_tdata_q  <= tx_tdata_d;
      last_q      <= last_d;
      error_q     <= error_d;
      for (int i = 0; i < QUEUES; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

  assign tx_tvalid = tx_tvalid_q;
  assign tx_tid    = tx_tid_q;
  assign tx_tdest  = tx_tdest_q;
  assign tx_tdata  = tx_tdata_q;
  assign rsp_tlast = rx_tlast;
  assign rsp_tdata = rx_tdata;
  assign error     = error_q;

endmodule

// File: tb/tb_virtio_available_ring_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level reference model of the scheduler.
module tb_virtio_available_ring_scheduler;

  localparam int QUEUES = 4;
  localparam int MAXO   = 4;

  logic         aclk = 1'b0;
  logic         areset;
  logic [3:0]   enable, req_tvalid, req_tready;
  logic [7:0]   req_tid;
  logic [127:0] req_tdata;
  logic         tx_tvalid, tx_tready;
  logic [1:0]   tx_tid, tx_tdest;
  logic [31:0]  tx_tdata;
  logic         rx_tvalid, rx_tready, rx_tlast;
  logic [1:0]   rx_tdest;
  logic [31:0]  rx_tdata;
  logic [3:0]   rsp_tvalid, rsp_tready;
  logic         rsp_tlast;
  logic [31:0]  rsp_tdata;
  logic         error;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: credits per queue, round-robin pointer, output slot, error.
  int          m_credit [QUEUES];
  int          m_last;
  logic        m_tv;
  logic [1:0]  m_tid, m_tdest;
  logic [31:0] m_tdata;
  logic        m_err;
  int          e_grant;
  logic        e_loadable;
  logic [3:0]  e_req_tready;
  logic        e_rx_tready;
  logic [3:0]  e_rsp_tvalid;

  always #5 aclk = ~aclk;

  virtio_available_ring_scheduler #(.QUEUES(QUEUES), .MAX_OUTSTANDING(MAXO)) dut (
    .aclk(aclk), .areset(areset), .enable(enable),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tid(req_tid), .req_tdata(req_tdata),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tid(tx_tid), .tx_tdest(tx_tdest),
    .tx_tdata(tx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdest(rx_tdest),
    .rx_tlast(rx_tlast), .rx_tdata(rx_tdata), .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready),
    .rsp_tlast(rsp_tlast), .rsp_tdata(rsp_tdata), .error(error)
  );

  // Decide what the scheduler should do this cycle from the current inputs.
  task automatic model_eval();
    int q;
    e_loadable = !m_tv || tx_tready;
    e_grant    = -1;
    if (e_loadable && !areset) begin
      for (int k = 1; k <= QUEUES; k++) begin
        q = (m_last + k) % QUEUES;
        if (e_grant < 0 && enable[q] && req_tvalid[q] && m_credit[q] < MAXO) e_grant = q;
      end
    end
    e_req_tready = (e_grant >= 0) ? 4'(1 << e_grant) : 4'b0000;
    e_rx_tready  = rsp_tready[rx_tdest];
    e_rsp_tvalid = rx_tvalid ? 4'(1 << rx_tdest) : 4'b0000;
  endtask

  // Apply the cycle's decisions at the clock edge.
  task automatic model_commit();
    int q;
    if (areset) begin
      for (int i = 0; i < QUEUES; i++) m_credit[i] = 0;
      m_last = QUEUES - 1; m_tv = 1'b0; m_tid = '0; m_tdest = '0; m_tdata = '0; m_err = 1'b0;
    end else begin
      if (rx_tvalid && e_rx_tready && rx_tlast) begin
        q = int'(rx_tdest);
        if (m_credit[q] == 0) m_err = 1'b1;
        else m_credit[q] = m_credit[q] - 1;
      end
      if (e_grant >= 0) begin
        m_credit[e_grant] = m_credit[e_grant] + 1;
        m_tv    = 1'b1;
        m_tid   = req_tid[2*e_grant +: 2];
        m_tdest = 2'(e_grant);
        m_tdata = req_tdata[32*e_grant +: 32];
        m_last  = e_grant;
      end else if (e_loadable) begin
        m_tv = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    model_commit();
    #1;
  endtask

  task automatic settle();
    #2;
    model_eval();
  endtask

  task automatic idle_inputs();
    enable = '0; req_tvalid = '0; req_tid = '0; req_tdata = '0; tx_tready = 1'b0;
    rx_tvalid = 1'b0; rx_tdest = '0; rx_tlast = 1'b0; rx_tdata = '0; rsp_tready = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    areset = 1'b1;
    settle(); tick();
    settle(); tick();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    areset = 1'b1; enable = 4'hF; req_tvalid = 4'hF; tx_tready = 1'b1;
    settle();
    tests_run++;
    if (req_tready !== 4'b0000) begin tests_failed++; $display("FAIL reset_req_tready_in_reset got=%b exp=0000", req_tready); end
    tick(); settle(); tick();
    areset = 1'b0; req_tvalid = '0;
    settle();
    tests_run++;
    if ({tx_tvalid, tx_tid, tx_tdest, tx_tdata, error} !== 38'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got tv=%b tid=%h dest=%h data=%h err=%b exp=all zero", tx_tvalid, tx_tid, tx_tdest, tx_tdata, error);
    end
    tests_run++;
    if (req_tready !== 4'b0000) begin tests_failed++; $display("FAIL reset_req_tready got=%b exp=0000", req_tready); end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    enable = 4'hF; req_tvalid = 4'hF; tx_tready = 1'b1;
    req_tdata = {$urandom, $urandom, $urandom, $urandom}; req_tid = 8'($urandom);
    for (int n = 0; n < 16; n++) begin
      settle();
      tests_run++;
      if (req_tready !== 4'(1 << (n % 4))) begin tests_failed++; $display("FAIL rr_grant_%0d got=%b exp=%b", n, req_tready, 4'(1 << (n % 4))); end
      if (n > 0) begin
        tests_run++;
        if (tx_tvalid !== 1'b1 || tx_tdest !== 2'((n - 1) % 4)) begin
          tests_failed++; $display("FAIL rr_tdest_%0d got=%b/%0d exp=1/%0d", n, tx_tvalid, tx_tdest, (n - 1) % 4);
        end
      end
      tick();
    end
    settle();
    tests_run++;
    if (req_tready !== 4'b0000) begin tests_failed++; $display("FAIL rr_exhausted_tready got=%b exp=0000", req_tready); end
    tick(); settle();
    tests_run++;
    if (tx_tvalid !== 1'b0) begin tests_failed++; $display("FAIL rr_idle_tvalid got=%b exp=0", tx_tvalid); end
    for (int i = 0; i < QUEUES; i++) begin
      tests_run++;
      if (dut.credit_q[i] !== 8'(MAXO)) begin tests_failed++; $display("FAIL rr_credit_%0d got=%0d exp=%0d", i, dut.credit_q[i], MAXO); end
    end
    tick();
  endtask

  task automatic test_single_request();
    do_reset();
    enable = 4'hF; tx_tready = 1'b1; req_tvalid = 4'b0100;
    req_tid[5:4] = 2'd1; req_tdata[95:64] = 32'h0008_0010;
    settle();
    tests_run++;
    if (req_tready !== 4'b0100) begin tests_failed++; $display("FAIL single_req_tready got=%b exp=0100", req_tready); end
    tick();
    req_tvalid = '0;
    settle();
    tests_run++;
    if ({tx_tvalid, tx_tdest, tx_tid, tx_tdata} !== {1'b1, 2'd2, 2'd1, 32'h0008_0010}) begin
      tests_failed++;
      $display("FAIL single_tx got tv=%b dest=%0d tid=%0d data=%h exp tv=1 dest=2 tid=1 data=00080010", tx_tvalid, tx_tdest, tx_tid, tx_tdata);
    end
    tick();
  endtask

  task automatic test_back_to_back_stall();
    logic [36:0] held;
    do_reset();
    enable = 4'hF; req_tvalid = 4'b0011; tx_tready = 1'b1;
    req_tdata = {$urandom, $urandom, $urandom, $urandom}; req_tid = 8'($urandom);
    settle(); tick();
    tx_tready = 1'b0;
    held = '0;
    for (int n = 0; n < 5; n++) begin
      settle();
      if (n == 0) begin
        held = {tx_tvalid, tx_tid, tx_tdest, tx_tdata};
        tests_run++;
        if (held !== {1'b1, req_tid[1:0], 2'd0, req_tdata[31:0]}) begin tests_failed++; $display("FAIL stall_loaded got=%h exp=%h", held, {1'b1, req_tid[1:0], 2'd0, req_tdata[31:0]}); end
      end
      tests_run++;
      if ({tx_tvalid, tx_tid, tx_tdest, tx_tdata} !== held || req_tready !== 4'b0000) begin
        tests_failed++; $display("FAIL stall_hold_%0d got=%h/%b exp=%h/0000", n, {tx_tvalid, tx_tid, tx_tdest, tx_tdata}, req_tready, held);
      end
      tick();
    end
    tx_tready = 1'b1;
    settle();
    tests_run++;
    if (req_tready !== 4'b0010) begin tests_failed++; $display("FAIL stall_release_grant got=%b exp=0010", req_tready); end
    tick(); settle();
    tests_run++;
    if (tx_tvalid !== 1'b1 || tx_tdest !== 2'd1) begin tests_failed++; $display("FAIL stall_release_tdest got=%b/%0d exp=1/1", tx_tvalid, tx_tdest); end
    tick();
  endtask

  task automatic test_credit_return();
    do_reset();
    enable = 4'hF; req_tvalid = 4'b0010; tx_tready = 1'b1; rsp_tready = 4'hF;
    for (int n = 0; n < MAXO; n++) begin
      settle();
      tests_run++;
      if (req_tready !== 4'b0010) begin tests_failed++; $display("FAIL credit_fill_%0d got=%b exp=0010", n, req_tready); end
      tick();
    end
    settle();
    tests_run++;
    if (req_tready !== 4'b0000 || dut.credit_q[1] !== 8'd4) begin tests_failed++; $display("FAIL credit_full got=%b/%0d exp=0000/4", req_tready, dut.credit_q[1]); end
    tick();
    rx_tvalid = 1'b1; rx_tdest = 2'd1; rx_tlast = 1'b1; rx_tdata = $urandom;
    settle();
    tests_run++;
    if (rx_tready !== 1'b1 || rsp_tvalid !== 4'b0010 || req_tready !== 4'b0000) begin
      tests_failed++; $display("FAIL credit_rsp got rxr=%b rspv=%b reqr=%b exp 1/0010/0000", rx_tready, rsp_tvalid, req_tready);
    end
    tick();
    rx_tvalid = 1'b0;
    settle();
    tests_run++;
    if (dut.credit_q[1] !== 8'd3 || req_tready !== 4'b0010) begin tests_failed++; $display("FAIL credit_returned got=%0d/%b exp=3/0010", dut.credit_q[1], req_tready); end
    tick(); settle();
    tests_run++;
    if (dut.credit_q[1] !== 8'd4 || req_tready !== 4'b0000 || tx_tdest !== 2'd1 || tx_tvalid !== 1'b1) begin
      tests_failed++; $display("FAIL credit_regrant got=%0d/%b/%0d/%b exp=4/0000/1/1", dut.credit_q[1], req_tready, tx_tdest, tx_tvalid);
    end
    tick();
  endtask

  task automatic test_response_routing();
    do_reset();
    rx_tvalid = 1'b1; rx_tdest = 2'd1; rx_tlast = 1'b1; rx_tdata = $urandom; rsp_tready = 4'b1101;
    settle();
    tests_run++;
    if (rx_tready !== 1'b0 || rsp_tvalid !== 4'b0010) begin tests_failed++; $display("FAIL route_blocked got=%b/%b exp=0/0010", rx_tready, rsp_tvalid); end
    tests_run++;
    if (rsp_tdata !== rx_tdata || rsp_tlast !== 1'b1) begin tests_failed++; $display("FAIL route_passthrough got=%h/%b exp=%h/1", rsp_tdata, rsp_tlast, rx_tdata); end
    tick();
    rsp_tready = 4'hF;
    settle();
    tests_run++;
    if (error !== 1'b0 || rx_tready !== 1'b1) begin tests_failed++; $display("FAIL route_no_fire got err=%b rxr=%b exp 0/1", error, rx_tready); end
    tick();
    rx_tvalid = 1'b0;
    settle(); tick(); settle(); tick(); settle();
    tests_run++;
    if (error !== 1'b1) begin tests_failed++; $display("FAIL route_underflow_error got=%b exp=1", error); end
    tests_run++;
    if (dut.credit_q[1] !== 8'd0) begin tests_failed++; $display("FAIL route_no_underflow got=%0d exp=0", dut.credit_q[1]); end
    tick();
    do_reset();
    settle();
    tests_run++;
    if (error !== 1'b0) begin tests_failed++; $display("FAIL route_error_cleared got=%b exp=0", error); end
    tick();
  endtask

  task automatic test_reset_midop();
    do_reset();
    enable = 4'hF; req_tvalid = 4'hF; tx_tready = 1'b1; rsp_tready = 4'hF;
    req_tdata = {$urandom, $urandom, $urandom, $urandom}; req_tid = 8'($urandom);
    for (int n = 0; n < 3; n++) begin settle(); tick(); end
    tx_tready = 1'b0;
    settle();
    tests_run++;
    if (tx_tvalid !== 1'b1 || tx_tdest !== 2'd2) begin tests_failed++; $display("FAIL midop_loaded got=%b/%0d exp=1/2", tx_tvalid, tx_tdest); end
    tick();
    areset = 1'b1;
    settle(); tick();
    settle();
    tests_run++;
    if ({tx_tvalid, tx_tid, tx_tdest, tx_tdata, error, req_tready} !== 42'd0) begin
      tests_failed++; $display("FAIL midop_reset_outputs got tv=%b tid=%h dest=%h data=%h err=%b reqr=%b exp all zero", tx_tvalid, tx_tid, tx_tdest, tx_tdata, error, req_tready);
    end
    tests_run++;
    if ({dut.credit_q[0], dut.credit_q[1], dut.credit_q[2], dut.credit_q[3]} !== 32'd0) begin
      tests_failed++; $display("FAIL midop_credits got=%0d,%0d,%0d,%0d exp=0", dut.credit_q[0], dut.credit_q[1], dut.credit_q[2], dut.credit_q[3]);
    end
    tick();
    areset = 1'b0; tx_tready = 1'b1;
    settle();
    tests_run++;
    if (req_tready !== 4'b0001) begin tests_failed++; $display("FAIL midop_first_grant got=%b exp=0001", req_tready); end
    tick();
    req_tvalid = '0; rx_tvalid = 1'b1; rx_tdest = 2'd2; rx_tlast = 1'b1;
    settle(); tick();
    rx_tvalid = 1'b0;
    settle();
    tests_run++;
    if (error !== 1'b1) begin tests_failed++; $display("FAIL midop_stale_rsp_error got=%b exp=1", error); end
    tick();
  endtask

  task automatic test_random();
    int live [$];
    do_reset();
    for (int n = 0; n < 400; n++) begin
      enable     = 4'($urandom | $urandom);
      req_tvalid = 4'($urandom);
      req_tid    = 8'($urandom);
      req_tdata  = {$urandom, $urandom, $urandom, $urandom};
      tx_tready  = ($urandom % 4) != 0;
      rsp_tready = 4'($urandom | $urandom);
      rx_tdata   = $urandom;
      rx_tlast   = 1'($urandom);
      live.delete();
      for (int i = 0; i < QUEUES; i++) if (m_credit[i] > 0) live.push_back(i);
      rx_tvalid = (live.size() > 0) && ($urandom % 2 == 0);
      rx_tdest  = (live.size() > 0) ? 2'(live[$urandom % live.size()]) : 2'($urandom);
      settle();
      tests_run++;
      if ({req_tready, rx_tready, rsp_tvalid, tx_tvalid, tx_tdest, tx_tid, tx_tdata, error, rsp_tdata, rsp_tlast}
          !== {e_req_tready, e_rx_tready, e_rsp_tvalid, m_tv, m_tdest, m_tid, m_tdata, m_err, rx_tdata, rx_tlast}) begin
        tests_failed++;
        $display("FAIL random_cycle_%0d got reqr=%b rxr=%b rspv=%b tv=%b dest=%0d tid=%0d data=%h err=%b exp reqr=%b rxr=%b rspv=%b tv=%b dest=%0d tid=%0d data=%h err=%b",
                 n, req_tready, rx_tready, rsp_tvalid, tx_tvalid, tx_tdest, tx_tid, tx_tdata, error,
                 e_req_tready, e_rx_tready, e_rsp_tvalid, m_tv, m_tdest, m_tid, m_tdata, m_err);
      end
      tick();
    end
    for (int i = 0; i < QUEUES; i++) begin
      tests_run++;
      if (dut.credit_q[i] !== 8'(m_credit[i])) begin tests_failed++; $display("FAIL random_credit_%0d got=%0d exp=%0d", i, dut.credit_q[i], m_credit[i]); end
    end
  endtask

  initial begin
    areset = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_single_request();
    test_back_to_back_stall();
    test_credit_return();
    test_response_routing();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
